// File: rtl/kbd_scan_4x4.sv
// kbd_scan_4x4: 4x4 matrix keypad scanner with press/release debounce.
// Drives one active-low row at a time, samples the synchronized columns on
// the last phase of each row slot, debounces a single key and reports its
// code (row_index*4 + col_index) with a one-cycle valid pulse.
//
// Key event timing (4 cycles per row slot, 16 cycles per full sweep):
//   - key_valid is a single-cycle pulse. In that same cycle key_code takes
//     the new value and key_down rises.
//   - key_valid fires DEBOUNCE_CNT cycles after the candidate is captured.
//   - key_down falls DEBOUNCE_CNT cycles after the first high sample of an
//     unbroken high run.
module kbd_scan_4x4 #(
    parameter int DEBOUNCE_CNT = 100
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] row,
    input  logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CNT - 1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] sync1;
    logic [3:0] cs;
    logic [1:0] ph;
    logic [1:0] ri;
    logic [1:0] cidx;
    logic [7:0] cnt;
    logic [1:0] low_col;
    logic       cand_low;

    // Column sense is asynchronous: two-flop synchronizer, idle value all-high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 4'b1111;
            cs    <= 4'b1111;
        end else begin
            sync1 <= col;
            cs    <= sync1;
        end
    end

    // Pick the lowest-index low column; only meaningful when cs != 4'b1111.
    always_comb begin
        low_col = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!cs[i]) begin
                low_col = 2'(i);
            end
        end
    end

    // Synchronized level of the column belonging to the key being tracked.
    assign cand_low = ~cs[cidx];

    // Row drive follows the registered row index; exactly one bit low.
    assign row = ~(4'b0001 << ri);

    // Scan / debounce / held state machine with registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= SCAN;
            ph        <= 2'd0;
            ri        <= 2'd0;
            cidx      <= 2'd0;
            cnt       <= 8'd0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            case (state)
                SCAN: begin
                    if (ph != 2'd3) begin
                        ph <= ph + 2'd1;
                    end else if (cs == 4'b1111) begin
                        ri <= ri + 2'd1;
                        ph <= 2'd0;
                    end else begin
                        cidx  <= low_col;
                        cnt   <= 8'd0;
                        ph    <= 2'd0;
                        state <= DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (cand_low) begin
                        if (cnt == CNT_LAST) begin
                            key_code  <= {ri, cidx};
                            key_valid <= 1'b1;
                            key_down  <= 1'b1;
                            cnt       <= 8'd0;
                            state     <= HELD;
                        end else if (cnt != 8'hFF) begin
                            cnt <= cnt + 8'd1;
                        end
                    end else begin
                        // Bounce: abandon candidate, rescan the same row from phase 0.
                        ph    <= 2'd0;
                        state <= SCAN;
                    end
                end
                HELD: begin
                    if (!cand_low) begin
                        if (cnt == CNT_LAST) begin
                            key_down <= 1'b0;
                            cnt      <= 8'd0;
                            ri       <= ri + 2'd1;
                            ph       <= 2'd0;
                            state    <= SCAN;
                        end else if (cnt != 8'hFF) begin
                            cnt <= cnt + 8'd1;
                        end
                    end else begin
                        // Any low sample restarts the release count.
                        cnt <= 8'd0;
                    end
                end
                default: begin
                    state <= SCAN;
                    ph    <= 2'd0;
                    cnt   <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: doc/kbd_scan_4x4.md
# kbd_scan_4x4

Scans a 4x4 matrix keypad for paddle and menu input in the Pong design. It drives the rows one at a time, samples the columns, debounces a single key press and release, and reports a 4-bit key code with a one-cycle valid pulse. It sits directly downstream of the 10 kHz clock divider: its `clk` is that divider's output, so every timing figure below is in 100 µs cycles.

## Interface
Parameters:
- `DEBOUNCE_CNT`, default 100: consecutive stable samples needed to accept a press or a release (100 = 10 ms). Legal range is 2..255.

Ports:
- `clk`  input  1  10 kHz scan clock (from the divider)
- `rst`  input  1  asynchronous, active-low reset
- `row`  output 4  row drive, active-low, exactly one bit low at any time
- `col`  input  4  column sense, active-low (board pull-ups), asynchronous to `clk`
- `key_code`  output 4  code of the last accepted key, computed as row_index*4 + col_index
- `key_valid`  output 1  one-cycle pulse when a press is accepted
- `key_down`  output 1  high from press acceptance until release acceptance

## Operation
- `col` passes through a 2-flop synchronizer; all decisions use the synchronized value `cs`.
- State machine has three states: SCAN, DEBOUNCE, HELD.
- 2-bit phase counter `ph` and 2-bit row index `ri`; `row` = ~(1 << `ri`).
- **SCAN:**
  - Each row is driven for 4 cycles (`ph` 0..3).
  - Sample `cs` only at `ph`==3.
  - If all columns are high, `ri` advances (3 wraps to 0) and `ph` returns to 0.
  - If any column is low, capture `ri` and the lowest-index low column `c` as the candidate code, clear the debounce counter, and go to DEBOUNCE.
- **DEBOUNCE:**
  - `row` stays frozen.
  - Each cycle `cs[c]` is low, the counter increments.
  - When the counter reaches `DEBOUNCE_CNT`-1 on a low sample, load `key_code` with the candidate, pulse `key_valid`, set `key_down`, clear the counter, and go to HELD.
  - Any high sample of `cs[c]` returns to SCAN at the same `ri` with `ph`=0; outputs are unchanged.
- **HELD:**
  - `row` stays frozen and other columns are ignored.
  - A high `cs[c]` increments the counter; a low sample clears it.
  - When the counter reaches `DEBOUNCE_CNT`-1 on a high sample, clear `key_down` and go to SCAN with `ri`+1 and `ph`=0.
- Multiple simultaneous keys: only the lowest column in the first row found is handled. There is no rollover or queuing.
- The counter is 8 bits and saturates; it never wraps.
- `key_code` holds its value between presses.

## Timing
- Reset values: `row`=4'b1110, `key_code`=0, `key_valid`=0, `key_down`=0, state SCAN, `ri`=0, `ph`=0, counter 0, synchronizer flops 4'b1111.
- Asynchronous reset takes effect immediately, including in the middle of DEBOUNCE or HELD. No pulse is emitted on reset exit.
- `key_valid` is high for exactly one cycle, in the same cycle `key_code` takes its new value and `key_down` rises.
- Press latency: `key_valid` goes high `DEBOUNCE_CNT` cycles after DEBOUNCE is entered, provided every sample is low. Worst-case detection delay before DEBOUNCE is 16 cycles of scan plus 2 cycles of synchronizer.
- Release latency: `key_down` falls `DEBOUNCE_CNT` cycles after the first of an unbroken run of high samples.
- A full scan sweep takes 16 cycles (1.6 ms).
- A glitch of one cycle in DEBOUNCE aborts the candidate. A glitch in HELD restarts the release count and does not drop `key_down`.

## Test plan
- **Reset and idle:** with `rst` low, then released and `col`=4'b1111 for 64 cycles -> `row` cycles 1110, 1101, 1011, 0111, each held 4 cycles. `key_valid` never asserts and `key_code` stays 0.
- **Clean press:** with `DEBOUNCE_CNT`=4, pull col[2] low only while `row`[1] is low, held for 20 cycles -> one `key_valid` pulse with `key_code`=6, `key_down`=1, and `row` frozen at 1101.
- **Bounce abort:** col[0] low on row 3 for 2 cycles in DEBOUNCE, then high -> no `key_valid`, and scanning resumes at row 3 with `ph`=0.
- **Release debounce:** while key 6 is held, release it, bounce low once after 2 high cycles, then stay high -> `key_down` falls only after 4 consecutive high samples, and scanning resumes with `row`=1011.
- **Simultaneous keys:** col[1] and col[3] both low on row 0 -> `key_code`=1 and exactly one pulse. A second key pressed during HELD is ignored.
- **Reset mid-operation:** assert `rst` during HELD -> all outputs return to their reset values immediately, and after release the scan restarts at `row`=1110.
